ppu_sum_acc: RTL and testbench
==============================

Name: ppu_sum_acc

Overview:
- Sequential accumulator directly downstream of the PPU saturating adder tree.
- Consumes one adder-tree partial sum per beat and accumulates beats of a frame with the same unsigned saturating rule as the tree.
- Presents the frame total, beat count and flags on a valid/ready output for the next PPU stage.
- Used when a vector is too wide for one tree pass and is streamed through the tree in chunks.

Parameters:
- DATA_WIDTH, 8, width of input partial sums and output total (unsigned).
- MAX_BEATS, 16, maximum beats per frame; frame force-closed at this count.
- CNT_WIDTH, $clog2(MAX_BEATS+1), width of beat counter / m_beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  partial sum valid.
- s_ready  out  1  accumulator can accept a beat.
- s_sum  in  DATA_WIDTH  partial sum from adder tree (unsigned, already saturated).
- s_last  in  1  final beat of frame.
- m_valid  out  1  frame total valid.
- m_ready  in  1  downstream accepts total.
- m_sum  out  DATA_WIDTH  saturated frame total.
- m_beats  out  CNT_WIDTH  number of beats in frame (1..MAX_BEATS).
- m_sat  out  1  saturation occurred at any point in frame (sticky).
- m_overrun  out  1  frame closed at MAX_BEATS without s_last.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled at clk edge with rst=1:
  - state=IDLE; acc=0; beat_cnt=0; sat_flag=0.
  - m_valid=0, m_sum=0, m_beats=0, m_sat=0, m_overrun=0.
  - s_ready=0 while rst=1.
  - Reset mid-frame or while holding a result discards everything; no output is produced for that frame.
- States:
  - IDLE: no beat accepted yet in current frame.
  - ACCUM: at least one beat accepted, frame open.
  - HOLD: result registered, awaiting m_ready.
- s_ready = !rst && (state != HOLD). Registered state only; no combinational path from m_ready to s_ready.
- Beat accept = s_valid && s_ready:
  - base = (state==IDLE) ? 0 : acc.
  - tmp[DATA_WIDTH:0] = base + s_sum.
  - acc_next = tmp[DATA_WIDTH] ? all-ones : tmp[DATA_WIDTH-1:0].
  - sat_next = (state==IDLE ? 0 : sat_flag) | tmp[DATA_WIDTH].
  - cnt_next = (state==IDLE ? 0 : beat_cnt) + 1.
  - Once acc is all-ones it stays all-ones: sticky by arithmetic, since adding 0 keeps all-ones.
- Frame close when accept && (s_last || cnt_next==MAX_BEATS):
  - Next cycle: state=HOLD; m_valid=1; m_sum=acc_next; m_beats=cnt_next; m_sat=sat_next.
  - m_overrun = !s_last. If s_last and cnt_next==MAX_BEATS coincide, m_overrun=0.
- Accept without close: state=ACCUM; registers updated.
- No accept: all state held, in IDLE or ACCUM.
- HOLD:
  - m_* outputs stable while m_valid && !m_ready.
  - On m_ready: m_valid=0 next cycle, state=IDLE.
  - m_sum, m_beats and the flags keep their last values after m_valid drops; only m_valid qualifies them.
- Latency: last beat accepted at cycle N → m_valid=1 at N+1.
- Throughput: one bubble cycle per frame. The earliest next-frame beat is accepted the cycle after the m_ready handshake.
- Single-beat frame (s_last on first beat): m_sum=s_sum, m_beats=1, m_sat=0.
- s_last and s_sum ignored when s_valid=0.
- m_ready ignored when m_valid=0.

Decomposition:
- Shared package ppu_pkg: state enum (IDLE/ACCUM/HOLD) and a sat_add function (DATA_WIDTH+1 add, clamp to all-ones on carry). The function is shared with the adder-tree rule so both stages saturate identically.
- No sub-module is needed; a single always block plus next-state logic suffices.

Test Plan (DATA_WIDTH=8, MAX_BEATS=4):
1. Beats 10,20,30(last), m_ready=1 → one cycle after beat 3: m_valid=1, m_sum=60, m_beats=3, m_sat=0, m_overrun=0; s_ready=0 that cycle, 1 the next.
2. Beats 200,100(last) → m_sum=255, m_sat=1. Then frame 5(last) → m_sum=5, m_sat=0 (flag cleared per frame).
3. Five beats of 1, none with last → first result m_sum=4, m_beats=4, m_overrun=1. Fifth beat is accepted only after the handshake and starts a new frame.
4. Result held with m_ready=0 for 6 cycles, s_valid=1 throughout → m_* stable, s_ready=0, no beat consumed. m_ready=1 → m_valid=0 next cycle, pending beat accepted the cycle after.
5. rst=1 asserted mid-frame after 2 beats, then frame 7(last) → m_sum=7, m_beats=1. Outputs are zero during reset, s_ready=0.
6. Frame with s_last on beat 4 (=MAX_BEATS), values 64 each → m_sum=255, m_sat=1, m_beats=4, m_overrun=0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: accumulator state encoding and the unsigned
// saturating add used by both the adder tree and the sum accumulator.
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } ppu_state_e;

    localparam int SAT_MAXW = 32;

    // Add at width w (w <= SAT_MAXW) and clamp to all-ones on carry out of bit w-1.
    // Result bit SAT_MAXW is the carry (saturation) flag.
    function automatic logic [SAT_MAXW:0] sat_add(
        input logic [SAT_MAXW-1:0] a,
        input logic [SAT_MAXW-1:0] b,
        input int unsigned         w
    );
        logic [SAT_MAXW:0]   tmp;
        logic [SAT_MAXW-1:0] ones;
        tmp  = {1'b0, a} + {1'b0, b};
        ones = {SAT_MAXW{1'b1}} >> (SAT_MAXW - w);
        if (tmp[w]) begin
            return {1'b1, ones};
        end
        return {1'b0, tmp[SAT_MAXW-1:0] & ones};
    endfunction

endpackage

// File: rtl/ppu_sum_acc.sv
// Frame accumulator behind the PPU adder tree: saturating sum of the beats of
// a frame, presented with beat count and sat/overrun flags on a valid/ready port.
module ppu_sum_acc
    import ppu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 16,
    parameter int CNT_WIDTH  = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_sum,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_sum,
    output logic [CNT_WIDTH-1:0]  m_beats,
    output logic                  m_sat,
    output logic                  m_overrun
);

    ppu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  sat_q, sat_d;
    logic [DATA_WIDTH-1:0] m_sum_q, m_sum_d;
    logic [CNT_WIDTH-1:0]  m_beats_q, m_beats_d;
    logic                  m_sat_q, m_sat_d;
    logic                  m_overrun_q, m_overrun_d;

    logic                       first_beat;
    logic [DATA_WIDTH-1:0]      base;
    logic [SAT_MAXW:0]          add_r;
    logic                       add_carry;
    logic [SAT_MAXW-DATA_WIDTH-1:0] add_hi_unused;
    logic [DATA_WIDTH-1:0]      add_sum;
    logic [CNT_WIDTH-1:0]       cnt_next;
    logic                       sat_next;
    logic                       accept;
    logic                       close;

    // s_ready depends on registered state only, never on m_ready.
    assign s_ready    = !rst && (state_q != ST_HOLD);
    assign accept     = s_valid && s_ready;
    assign first_beat = (state_q == ST_IDLE);

    assign base  = first_beat ? '0 : acc_q;
    assign add_r = sat_add(SAT_MAXW'(base), SAT_MAXW'(s_sum), unsigned'(DATA_WIDTH));
    assign {add_carry, add_hi_unused, add_sum} = add_r;

    assign cnt_next = (first_beat ? '0 : cnt_q) + CNT_WIDTH'(1);
    assign sat_next = (first_beat ? 1'b0 : sat_q) | add_carry;
    assign close    = accept && (s_last || (cnt_next == CNT_WIDTH'(MAX_BEATS)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        m_sum_d     = m_sum_q;
        m_beats_d   = m_beats_q;
        m_sat_d     = m_sat_q;
        m_overrun_d = m_overrun_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_next;
                    sat_d = sat_next;
                    if (close) begin
                        state_d     = ST_HOLD;
                        m_sum_d     = add_sum;
                        m_beats_d   = cnt_next;
                        m_sat_d     = sat_next;
                        m_overrun_d = !s_last;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            m_sum_q     <= '0;
            m_beats_q   <= '0;
            m_sat_q     <= 1'b0;
            m_overrun_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            m_sum_q     <= m_sum_d;
            m_beats_q   <= m_beats_d;
            m_sat_q     <= m_sat_d;
            m_overrun_q <= m_overrun_d;
        end
    end

    assign m_valid   = (state_q == ST_HOLD);
    assign m_sum     = m_sum_q;
    assign m_beats   = m_beats_q;
    assign m_sat     = m_sat_q;
    assign m_overrun = m_overrun_q;

endmodule

// File: tb/tb_ppu_sum_acc.sv
// Directed plus randomized bench for ppu_sum_acc (DATA_WIDTH=8, MAX_BEATS=4)
// against a frame-level saturating-sum model.
module tb_ppu_sum_acc;

    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int CW  = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_sum;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_sum;
    logic [CW-1:0] m_beats;
    logic          m_sat;
    logic          m_overrun;

    ppu_sum_acc #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sum     (s_sum),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_beats   (m_beats),
        .m_sat     (m_sat),
        .m_overrun (m_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int beats;
        int sat;
        int overrun;
    } result_t;

    result_t exp_q[$];
    int      cur_vals[$];
    int      total = 0;
    int      bad   = 0;
    bit      rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame model: plain integer sum clamped to 255; saturation if any running
    // partial sum exceeded 255.
    task automatic model_accept(input int v, input bit last, output bit closed);
        result_t r;
        int      run;
        bit      sat;
        cur_vals.push_back(v);
        closed = last || (cur_vals.size() == MB);
        if (closed) begin
            run = 0;
            sat = 1'b0;
            foreach (cur_vals[i]) begin
                run += cur_vals[i];
                if (run > 255) begin
                    run = 255;
                    sat = 1'b1;
                end
            end
            r.sum     = run;
            r.beats   = cur_vals.size();
            r.sat     = sat;
            r.overrun = !last;
            exp_q.push_back(r);
            cur_vals.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic [DW-1:0] v, input bit last);
        int waits = 0;
        bit closed;
        s_valid = 1'b1;
        s_sum   = v;
        s_last  = last;
        @(negedge clk);
        while (!s_ready) begin
            waits++;
            if (waits > 200) begin
                bad++;
                $display("FAIL accept_timeout observed=no_accept expected=accept");
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stuck");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sum   = DW'($urandom);
        s_last  = 1'($urandom);
        model_accept(v, last, closed);
        check("close_mvalid", {31'd0, m_valid}, {31'd0, closed});
        check("close_sready", {31'd0, s_ready}, {31'd0, !closed});
    endtask

    // Result monitor and hold-stability checker.
    bit            hold_prev = 1'b0;
    logic [31:0]   snap;
    always @(negedge clk) begin
        result_t e;
        if (!rst && hold_prev) begin
            check("hold_stable", {20'd0, m_valid, m_sum, m_beats, m_sat, m_overrun}, snap);
        end
        hold_prev = !rst && m_valid && !m_ready;
        snap      = {20'd0, m_valid, m_sum, m_beats, m_sat, m_overrun};
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("m_sum",     {24'd0, m_sum},       e.sum);
                check("m_beats",   {29'd0, m_beats},     e.beats);
                check("m_sat",     {31'd0, m_sat},       e.sat);
                check("m_overrun", {31'd0, m_overrun},   e.overrun);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sum   = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready",  {31'd0, s_ready},  0);
        check("rst_outputs", {20'd0, m_valid, m_sum, m_beats, m_sat, m_overrun}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_sready", {31'd0, s_ready}, 1);

        // 1: simple three-beat frame, then bubble
        send_beat(8'd10, 1'b0);
        send_beat(8'd20, 1'b0);
        send_beat(8'd30, 1'b1);
        @(posedge clk);
        #1;
        check("t1_sready_after", {31'd0, s_ready}, 1);
        check("t1_mvalid_after", {31'd0, m_valid}, 0);

        // 2: saturation, then flag cleared on the next frame
        send_beat(8'd200, 1'b0);
        send_beat(8'd100, 1'b1);
        send_beat(8'd5,   1'b1);

        // 3: overrun at MAX_BEATS; fifth beat waits for the handshake
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (4) send_beat(8'd1, 1'b0);
        fork
            send_beat(8'd1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join

        // 4: result held six cycles with a pending beat
        m_ready = 1'b0;
        send_beat(8'd2, 1'b1);
        fork
            send_beat(8'd9, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                check("t4_mvalid_drop", {31'd0, m_valid}, 0);
                check("t4_sready_back", {31'd0, s_ready}, 1);
            end
        join

        // 5: reset mid-frame discards partial frame
        @(posedge clk);
        #1;
        send_beat(8'd3, 1'b0);
        send_beat(8'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_sready",  {31'd0, s_ready}, 0);
        check("t5_rst_outputs", {20'd0, m_valid, m_sum, m_beats, m_sat, m_overrun}, 0);
        cur_vals.delete();
        exp_q.delete();
        rst = 1'b0;
        send_beat(8'd7, 1'b1);

        // 6: s_last coincides with MAX_BEATS
        repeat (3) send_beat(8'd64, 1'b0);
        send_beat(8'd64, 1'b1);

        // random frames with random back-pressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int b = 0; b < n; b++) begin
                logic [DW-1:0] v;
                v = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(150, 255))
                                                : DW'($urandom_range(0, 60));
                send_beat(v, (b == n - 1) && ($urandom_range(0, 2) != 0));
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_results", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
